cpu_run_ctrl: RTL

Run-control sequencer for the single-cycle CPU on the FPGA board. It turns a raw step push-button, a mode select and touchscreen-loaded parameters into a registered `cpu_clk_en` pulse train that drives the CPU clock gate (BUFGCE CE). It supports single step, run-N-cycles, run-to-breakpoint and free run. It sits between the board IO and the clock gate, and its status outputs feed the LCD display mux.

---
 rtl/cpu_dbg_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 54 +++++
 rtl/cpu_run_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the CPU run-control block: FSM states, run modes, config selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_dbg_pkg;

   // Run-control FSM states; the numeric values are shown on the LCD.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_RUN_WAIT = 2'd2,
      ST_RUN_CHK  = 2'd3
   } ctrl_state_t;

   // run_mode encodings
   localparam logic [1:0] MODE_STEP   = 2'd0;
   localparam logic [1:0] MODE_RUN_N  = 2'd1;
   localparam logic [1:0] MODE_RUN_BP = 2'd2;
   localparam logic [1:0] MODE_FREE   = 2'd3;

   // cfg_sel encodings
   localparam logic CFG_SEL_RUN_N   = 1'b0;
   localparam logic CFG_SEL_BP_ADDR = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, single-cycle press pulse.
// Latency: press_o rises 2 sync cycles + DB_CYCLES stable samples + 1 register after the button edge.
// Backpressure: none; press_o is a one-cycle strobe that is never held.
module btn_debounce #(
   parameter int DB_CYCLES = 10000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic press_o
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;

   // Count consecutive samples that disagree with the accepted level; flip after DB_CYCLES of them.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      press_d = level_d & ~level_q;
   end

   // Synchronizer, debounce state and registered press strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: step/run-N/run-to-breakpoint/free-run CE pulses for the CPU clock gate.
// Latency: first enable one cycle after the debounced press; breakpoint runs issue at most one enable per 2 cycles.
// Backpressure: none; a press in any running state aborts. Breakpoint logic is built only with CPU_RUN_BP_EN.
module cpu_run_ctrl
   import cpu_dbg_pkg::*;
#(
   parameter int DB_CYCLES = 10000,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_step,
   input  logic [1:0]       run_mode,
   input  logic             cfg_valid,
   input  logic             cfg_sel,
   input  logic [31:0]      cfg_value,
   input  logic [31:0]      cpu_pc,
   output logic             cpu_clk_en,
   output logic             run_busy,
   output logic             bp_hit,
   output logic [CNT_W-1:0] step_count,
   output logic [1:0]       ctrl_state
);

   logic             press;
   ctrl_state_t      state_q, state_d;
   logic             en_q, en_d;
   logic             mode_run_n_q, mode_run_n_d;
   logic [CNT_W-1:0] run_n_q, run_n_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] step_count_q, step_count_d;
`ifdef CPU_RUN_BP_EN
   logic [31:0]      bp_addr_q, bp_addr_d;
   logic             bp_hit_q, bp_hit_d;
`else
   logic             unused_pc;
   assign unused_pc = ^cpu_pc;
`endif

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (btn_step),
      .press_o (press)
   );

   // Config capture in IDLE plus next-state / enable decision. A config write in the
   // same cycle as the press is visible to the run via run_n_d.
   always_comb begin
      state_d      = state_q;
      en_d         = 1'b0;
      mode_run_n_d = mode_run_n_q;
      run_n_d      = run_n_q;
      remaining_d  = remaining_q;
`ifdef CPU_RUN_BP_EN
      bp_addr_d    = bp_addr_q;
      bp_hit_d     = bp_hit_q;
`endif
      if ((state_q == ST_IDLE) && cfg_valid) begin
         if (cfg_sel == CFG_SEL_RUN_N)
            run_n_d = CNT_W'(cfg_value);
`ifdef CPU_RUN_BP_EN
         else
            bp_addr_d = cfg_value;
`endif
      end

      case (state_q)
         ST_IDLE: begin
            if (press) begin
               mode_run_n_d = (run_mode == MODE_RUN_N);
               case (run_mode)
                  MODE_STEP: en_d = 1'b1;
                  MODE_RUN_N: begin
                     // remaining holds the count still owed after this cycle's enable
                     if (run_n_d != '0) begin
                        en_d        = 1'b1;
                        remaining_d = run_n_d - 1'b1;
                        if (run_n_d != CNT_W'(1))
                           state_d = ST_RUN;
                     end
                  end
`ifdef CPU_RUN_BP_EN
                  MODE_RUN_BP: begin
                     // unconditional first edge lets a run resume from a breakpoint
                     bp_hit_d = 1'b0;
                     en_d     = 1'b1;
                     state_d  = ST_RUN_WAIT;
                  end
`endif
                  default: begin
                     en_d    = 1'b1;
                     state_d = ST_RUN;
                  end
               endcase
            end
         end
         ST_RUN: begin
            if (press) begin
               state_d     = ST_IDLE;
               remaining_d = '0;
            end else begin
               en_d = 1'b1;
               if (mode_run_n_q) begin
                  remaining_d = remaining_q - 1'b1;
                  if (remaining_q == CNT_W'(1))
                     state_d = ST_IDLE;
               end
            end
         end
`ifdef CPU_RUN_BP_EN
         ST_RUN_WAIT: begin
            // idle cycle so cpu_pc reflects the last edge before it is compared
            if (press) state_d = ST_IDLE;
            else       state_d = ST_RUN_CHK;
         end
         ST_RUN_CHK: begin
            if (press) begin
               state_d = ST_IDLE;
            end else if (cpu_pc == bp_addr_q) begin
               bp_hit_d = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               en_d    = 1'b1;
               state_d = ST_RUN_WAIT;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      step_count_d = step_count_q + CNT_W'(en_d);
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         en_q         <= 1'b0;
         mode_run_n_q <= 1'b0;
         run_n_q      <= '0;
         remaining_q  <= '0;
         step_count_q <= '0;
`ifdef CPU_RUN_BP_EN
         bp_addr_q    <= '0;
         bp_hit_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         en_q         <= en_d;
         mode_run_n_q <= mode_run_n_d;
         run_n_q      <= run_n_d;
         remaining_q  <= remaining_d;
         step_count_q <= step_count_d;
`ifdef CPU_RUN_BP_EN
         bp_addr_q    <= bp_addr_d;
         bp_hit_q     <= bp_hit_d;
`endif
      end
   end

   // CE is forced high in reset so the CPU's own reset gets clock edges.
   assign cpu_clk_en = reset | en_q;
   assign run_busy   = (state_q != ST_IDLE);
   assign step_count = step_count_q;
   assign ctrl_state = state_q;
`ifdef CPU_RUN_BP_EN
   assign bp_hit     = bp_hit_q;
`else
   assign bp_hit     = 1'b0;
`endif

endmodule
